// File: rtl/bpred_pkg.sv
// Shared types for the branch-predictor counter table scheduler.
package bpred_pkg;

  // 2-bit saturating branch counter; bit [1] is the predicted direction.
  typedef logic [1:0] ctr_t;

  // Weakly not-taken.
  localparam ctr_t CTR_INIT = 2'b01;

  // Default index width of the reference update entry.
  localparam int BPRED_IDX_W = 4;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_RD = 2'd1,
    UPD_WR = 2'd2
  } sched_state_e;

  // Queued resolve update.
  typedef struct packed {
    logic [BPRED_IDX_W-1:0] idx;
    logic                   taken;
  } upd_entry_t;

  // Saturating counter step: taken moves toward 3, not-taken toward 0.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'b01;
    end else begin
      if (c != 2'b00) r = c - 2'b01;
    end
    return r;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Update FIFO: DEPTH-entry queue of update entries (DEPTH a power of two).
// A push into an empty queue becomes visible at the head on the next cycle.
module bpred_upd_fifo
  import bpred_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = upd_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  entry_t i_data,
  input  logic   i_pop,
  output logic   o_full,
  output logic   o_empty,
  output entry_t o_head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_LVL);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage write; data needs no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and level; simultaneous push and pop keep the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bpred_sched.sv
// Branch counter table owner: arbitrates fetch lookups against queued
// resolve updates and applies each update as a two-cycle read-modify-write.
// Optional statistics counters are built when BPRED_STATS_EN is defined.
//
// Handshake: a lookup transfers on a cycle where lk_valid && lk_ready, an
// update transfers on a cycle where up_valid && up_ready; the ready signals
// depend only on scheduler state and FIFO level, never on the valids.
module bpred_sched
  import bpred_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DEFER  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_taken,
  output logic             busy,
  output sched_state_e     dbg_state
`ifdef BPRED_STATS_EN
  ,
  output logic [15:0]      lk_count,
  output logic [15:0]      up_count
`endif
);

  localparam int         TBL_N     = 1 << IDX_W;
  localparam logic [7:0] DEFER_MAX = 8'(MAX_DEFER);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } entry_t;

  ctr_t             r_table [TBL_N];
  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [7:0]       r_defer;
  logic [IDX_W-1:0] r_rmw_idx;
  logic             r_rmw_taken;
  ctr_t             r_rmw_ctr;
  logic             r_pred_valid;
  logic             r_pred_taken;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  entry_t           w_fifo_head;
  entry_t           w_fifo_in;
  logic             w_push;
  logic             w_pop;
  logic             w_force;
  logic             w_lk_grant;

  assign w_fifo_in = '{idx: up_idx, taken: up_taken};
  assign up_ready  = !w_fifo_full;
  assign w_push    = up_valid && !w_fifo_full;

  bpred_upd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_fifo_in),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  // Next-state and arbitration: a full FIFO or exhausted defer budget forces an update.
  always_comb begin
    w_state_nxt = r_state;
    w_force     = w_fifo_full || (r_defer == DEFER_MAX);
    lk_ready    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        lk_ready = !w_force;
        if (!w_fifo_empty && (!lk_valid || w_force)) begin
          w_pop       = 1'b1;
          w_state_nxt = UPD_RD;
        end
      end
      UPD_RD:  w_state_nxt = UPD_WR;
      UPD_WR:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_lk_grant = lk_valid && lk_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Defer budget: counts lookup grants made while an update waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_defer <= '0;
    end else if (w_pop) begin
      r_defer <= '0;
    end else if (w_lk_grant && !w_fifo_empty && (r_defer != DEFER_MAX)) begin
      r_defer <= r_defer + 8'd1;
    end
  end

  // RMW register: capture the popped entry, then the current counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rmw_idx   <= '0;
      r_rmw_taken <= 1'b0;
      r_rmw_ctr   <= CTR_INIT;
    end else begin
      if (w_pop) begin
        r_rmw_idx   <= w_fifo_head.idx;
        r_rmw_taken <= w_fifo_head.taken;
      end
      if (r_state == UPD_RD) r_rmw_ctr <= r_table[r_rmw_idx];
    end
  end

  // Counter table: reinitialised on reset, written only in UPD_WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) r_table[i] <= CTR_INIT;
    end else if (r_state == UPD_WR) begin
      r_table[r_rmw_idx] <= ctr_next(r_rmw_ctr, r_rmw_taken);
    end
  end

  // Prediction output: one-cycle pulse per grant; direction held between grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= w_lk_grant;
      if (w_lk_grant) r_pred_taken <= r_table[lk_idx][1];
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign busy       = !w_fifo_empty || (r_state != IDLE);
  assign dbg_state  = r_state;

`ifdef BPRED_STATS_EN
  logic [15:0] r_lk_count;
  logic [15:0] r_up_count;

  // Saturating activity counters: accepted lookups and completed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lk_count <= '0;
      r_up_count <= '0;
    end else begin
      if (w_lk_grant && (r_lk_count != 16'hFFFF)) r_lk_count <= r_lk_count + 16'd1;
      if ((r_state == UPD_WR) && (r_up_count != 16'hFFFF)) r_up_count <= r_up_count + 16'd1;
    end
  end

  assign lk_count = r_lk_count;
  assign up_count = r_up_count;
`endif

endmodule

// File: tb/tb_bpred_sched.sv
// Testbench for bpred_sched: vector table, corner-case sequences and a
// randomized phase checked against a counter-array reference model.
module tb_bpred_sched;
  import bpred_pkg::*;

  localparam int IDX_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_DEFER  = 8;
  localparam int N_IDX      = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lk_valid = 1'b0;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_idx = '0;
  logic             pred_valid;
  logic             pred_taken;
  logic             up_valid = 1'b0;
  logic             up_ready;
  logic [IDX_W-1:0] up_idx = '0;
  logic             up_taken = 1'b0;
  logic             busy;
  sched_state_e     dbg_state;
`ifdef BPRED_STATS_EN
  logic [15:0]      lk_count;
  logic [15:0]      up_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];
  int model_ctr [N_IDX];

  typedef struct {
    bit is_lookup;
    int idx;
    bit taken;
    bit exp_taken;
  } vec_t;
  vec_t vecs[$];

  // Clock and reset
  always #5 clk = ~clk;

  bpred_sched #(
    .IDX_W      (IDX_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_DEFER  (MAX_DEFER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_valid   (lk_valid),
    .lk_ready   (lk_ready),
    .lk_idx     (lk_idx),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_idx     (up_idx),
    .up_taken   (up_taken),
    .busy       (busy),
    .dbg_state  (dbg_state)
`ifdef BPRED_STATS_EN
    ,
    .lk_count   (lk_count),
    .up_count   (up_count)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lk_valid = 1'b0;
    up_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic lookup(input int idx, input bit exp, input string name);
    lk_valid = 1'b1;
    lk_idx   = IDX_W'(idx);
    check({name, "_lk_ready"}, lk_ready, 1);
    cycle();
    lk_valid = 1'b0;
    check({name, "_pred_valid"}, pred_valid, 1);
    check({name, "_pred_taken"}, pred_taken, exp);
  endtask

  task automatic push(input int idx, input bit t, input string name);
    up_valid = 1'b1;
    up_idx   = IDX_W'(idx);
    up_taken = t;
    check({name, "_up_ready"}, up_ready, 1);
    cycle();
    up_valid = 1'b0;
  endtask

  // Reference model: counters move toward 3 on taken, toward 0 otherwise.
  function automatic int model_step(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  initial begin
    int grants;
    int stall;
    int n;
    bit seen;

    // Reset state
    #1;
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_busy", busy, 0);
    check("rst_lk_ready", lk_ready, 1);
    check("rst_up_ready", up_ready, 1);
    do_reset();

    // Vector table: updates run to completion before the following lookup.
    vecs.push_back(vec_t'{1'b1, 3, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 5, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 5, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 5, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 5, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 5, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 5, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 5, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 5, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 7, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 7, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 7, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 7, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 7, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 7, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 0, 1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_lookup) begin
        lookup(vecs[i].idx, vecs[i].exp_taken, $sformatf("vec%0d", i));
        cycle();
        check($sformatf("vec%0d_pulse", i), pred_valid, 0);
        check($sformatf("vec%0d_hold", i), pred_taken, vecs[i].exp_taken);
      end else begin
        push(vecs[i].idx, vecs[i].taken, $sformatf("vec%0d", i));
        wait_idle();
      end
    end

    // Defer limit: continuous lookups with one pending update.
    do_reset();
    lk_valid = 1'b1;
    lk_idx   = 4'd1;
    up_valid = 1'b1;
    up_idx   = 4'd9;
    up_taken = 1'b1;
    check("defer_first_lk_ready", lk_ready, 1);
    cycle();
    up_valid = 1'b0;
    grants = 0;
    while (lk_ready && grants < 40) begin
      grants++;
      cycle();
    end
    stall = 0;
    while (!lk_ready && stall < 40) begin
      stall++;
      cycle();
    end
    check("defer_grants", grants, MAX_DEFER);
    check("defer_stall", stall, 3);
    check("defer_resume", lk_ready, 1);
    lk_valid = 1'b0;
    wait_idle();
    lookup(9, 1'b1, "defer_applied");

    // Full FIFO with lookups held high; ordering is visible through saturation.
    do_reset();
    lk_valid = 1'b1;
    lk_idx   = 4'd0;
    push(2, 1'b0, "full_p0");
    lk_valid = 1'b1;
    push(2, 1'b0, "full_p1");
    lk_valid = 1'b1;
    push(2, 1'b1, "full_p2");
    lk_valid = 1'b1;
    push(2, 1'b1, "full_p3");
    lk_valid = 1'b1;
    up_valid = 1'b1;
    up_idx   = 4'd2;
    up_taken = 1'b0;
    check("full_up_ready", up_ready, 0);
    check("full_lk_ready", lk_ready, 0);
    check("full_busy", busy, 1);
    cycle();
    up_valid = 1'b0;
    stall = 1;
    while (!lk_ready && stall < 40) begin
      stall++;
      cycle();
    end
    check("full_stall", stall, 3);
    lk_valid = 1'b0;
    wait_idle();
    lookup(2, 1'b1, "full_order");

    // Reset during UPD_RD discards in-flight and queued work.
    do_reset();
    push(6, 1'b1, "mid_pre0");
    wait_idle();
    push(6, 1'b1, "mid_pre1");
    wait_idle();
    lookup(6, 1'b1, "mid_pre");
    seen = 1'b0;
    n = 0;
    up_valid = 1'b1;
    up_idx   = 4'd8;
    up_taken = 1'b1;
    while (!seen && n < 10) begin
      if (dbg_state == UPD_RD) seen = 1'b1;
      else begin
        cycle();
        n++;
      end
    end
    check("mid_reached_rd", seen, 1);
    up_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_pred_valid", pred_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("mid_busy_after", busy, 0);
    for (int i = 0; i < N_IDX; i++) lookup(i, 1'b0, $sformatf("mid_idx%0d", i));

    // Randomized traffic against the counter-array model.
    do_reset();
    for (int i = 0; i < N_IDX; i++) model_ctr[i] = 1;
    for (int r = 0; r < 25; r++) begin
      int n_up;
      int sent;
      int guard;
      bit grant;
      bit acc;
      int ui;
      bit ut;
      n_up  = $urandom_range(1, 6);
      sent  = 0;
      guard = 0;
      while (sent < n_up && guard < 60) begin
        ui       = $urandom_range(0, N_IDX - 1);
        ut       = 1'($urandom_range(0, 1));
        up_valid = 1'b1;
        up_idx   = IDX_W'(ui);
        up_taken = ut;
        lk_valid = 1'($urandom_range(0, 1));
        lk_idx   = IDX_W'($urandom_range(0, N_IDX - 1));
        acc      = up_ready;
        grant    = lk_valid && lk_ready;
        cycle();
        check("rnd_pred_valid", pred_valid, grant);
        if (acc) begin
          model_ctr[ui] = model_step(model_ctr[ui], ut);
          sent++;
        end
        guard++;
      end
      up_valid = 1'b0;
      lk_valid = 1'b0;
      wait_idle();
      for (int i = 0; i < N_IDX; i++) begin
        lk_valid = 1'b1;
        lk_idx   = IDX_W'(i);
        check("rnd_lk_ready", lk_ready, 1);
        exp_q.push_back((model_ctr[i] >= 2) ? 1'b1 : 1'b0);
        cycle();
        lk_valid = 1'b0;
        check("rnd_pv_scan", pred_valid, 1);
        if (exp_q.size() > 0) check($sformatf("rnd_r%0d_idx%0d", r, i), pred_taken, exp_q.pop_front());
      end
    end

`ifdef BPRED_STATS_EN
    // Statistics counters
    do_reset();
    check("stats_rst_lk", lk_count, 0);
    check("stats_rst_up", up_count, 0);
    for (int i = 0; i < 10; i++) lookup(i, 1'b0, "stats_lk");
    for (int i = 0; i < 3; i++) begin
      push(i, 1'b1, "stats_up");
      wait_idle();
    end
    check("stats_lk_count", lk_count, 10);
    check("stats_up_count", up_count, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
